// File: rtl/cond_pkg.sv
// rtl/cond_pkg.sv - condition codes, NZCV bit positions and flag-write select bits
package cond_pkg;

   typedef enum logic [3:0] {
      COND_EQ = 4'b0000,
      COND_NE = 4'b0001,
      COND_CS = 4'b0010,
      COND_CC = 4'b0011,
      COND_MI = 4'b0100,
      COND_PL = 4'b0101,
      COND_VS = 4'b0110,
      COND_VC = 4'b0111,
      COND_HI = 4'b1000,
      COND_LS = 4'b1001,
      COND_GE = 4'b1010,
      COND_LT = 4'b1011,
      COND_GT = 4'b1100,
      COND_LE = 4'b1101,
      COND_AL = 4'b1110,
      COND_NV = 4'b1111
   } cond_t;

   localparam int N_BIT = 3;
   localparam int Z_BIT = 2;
   localparam int C_BIT = 1;
   localparam int V_BIT = 0;

   // flagwrite_e[FW_NZ] updates N,Z; flagwrite_e[FW_CV] updates C,V
   localparam int FW_NZ = 1;
   localparam int FW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// rtl/cond_check.sv - evaluates a 4-bit condition code against the NZCV flags
module cond_check
   import cond_pkg::*;
(
   input  cond_t      cond_i,
   input  logic [3:0] flags_i,
   output logic       met_o
);

   logic n_f;
   logic z_f;
   logic c_f;
   logic v_f;

   assign n_f = flags_i[N_BIT];
   assign z_f = flags_i[Z_BIT];
   assign c_f = flags_i[C_BIT];
   assign v_f = flags_i[V_BIT];

   // Decode the condition against the current flags; code 1111 never passes
   always_comb begin
      met_o = 1'b0;
      case (cond_i)
         COND_EQ: met_o = z_f;
         COND_NE: met_o = ~z_f;
         COND_CS: met_o = c_f;
         COND_CC: met_o = ~c_f;
         COND_MI: met_o = n_f;
         COND_PL: met_o = ~n_f;
         COND_VS: met_o = v_f;
         COND_VC: met_o = ~v_f;
         COND_HI: met_o = c_f & ~z_f;
         COND_LS: met_o = ~c_f | z_f;
         COND_GE: met_o = (n_f == v_f);
         COND_LT: met_o = (n_f != v_f);
         COND_GT: met_o = ~z_f & (n_f == v_f);
         COND_LE: met_o = z_f | (n_f != v_f);
         COND_AL: met_o = 1'b1;
         COND_NV: met_o = 1'b0;
         default: met_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_exec_stage.sv
// rtl/cond_exec_stage.sv - NZCV register, conditional gating and EX/MEM pipeline register
module cond_exec_stage
   import cond_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int RAW   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall_m,
   input  logic             flush_e,
   input  logic             valid_e,
   input  logic [3:0]       cond_e,
   input  logic [1:0]       flagwrite_e,
   input  logic [3:0]       alu_flags_e,
   input  logic [WIDTH-1:0] alu_result_e,
   input  logic [WIDTH-1:0] write_data_e,
   input  logic [RAW-1:0]   wa_e,
   input  logic             regwrite_e,
   input  logic             memwrite_e,
   input  logic             pcsrc_e,
   input  logic             memtoreg_e,
   output logic             cond_ex_e,
   output logic [3:0]       flags_q,
   output logic             valid_m,
   output logic             regwrite_m,
   output logic             memwrite_m,
   output logic             pcsrc_m,
   output logic             memtoreg_m,
   output logic [WIDTH-1:0] alu_result_m,
   output logic [WIDTH-1:0] write_data_m,
   output logic [RAW-1:0]   wa_m
);

   logic       cond_met;
   logic       live_e;
   logic [3:0] flags_d;

   cond_check u_cond_check (
      .cond_i  (cond_t'(cond_e)),
      .flags_i (flags_q),
      .met_o   (cond_met)
   );

   // A killed or empty slot never passes, whatever its condition field says
   assign live_e    = valid_e & ~flush_e;
   assign cond_ex_e = live_e & cond_met;

   // Merge the ALU flags into NZCV per flag-write group; only passing instructions write
   always_comb begin
      flags_d = flags_q;
      if (cond_ex_e) begin
         if (flagwrite_e[FW_NZ]) begin
            flags_d[N_BIT] = alu_flags_e[N_BIT];
            flags_d[Z_BIT] = alu_flags_e[Z_BIT];
         end
         if (flagwrite_e[FW_CV]) begin
            flags_d[C_BIT] = alu_flags_e[C_BIT];
            flags_d[V_BIT] = alu_flags_e[V_BIT];
         end
      end
   end

   // Flag register: reset dominates, stall freezes it
   always_ff @(posedge clk) begin
      if (reset) begin
         flags_q <= 4'b0000;
      end else if (!stall_m) begin
         flags_q <= flags_d;
      end
   end

   // EX/MEM register: side effects gated by the condition, memtoreg only by liveness
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_m      <= 1'b0;
         regwrite_m   <= 1'b0;
         memwrite_m   <= 1'b0;
         pcsrc_m      <= 1'b0;
         memtoreg_m   <= 1'b0;
         alu_result_m <= '0;
         write_data_m <= '0;
         wa_m         <= '0;
      end else if (!stall_m) begin
         valid_m      <= live_e;
         regwrite_m   <= regwrite_e & cond_ex_e;
         memwrite_m   <= memwrite_e & cond_ex_e;
         pcsrc_m      <= pcsrc_e & cond_ex_e;
         memtoreg_m   <= memtoreg_e & live_e;
         alu_result_m <= alu_result_e;
         write_data_m <= write_data_e;
         wa_m         <= wa_e;
      end
   end

endmodule

// File: tb/tb_cond_exec_stage.sv
// tb/tb_cond_exec_stage.sv - self-checking bench for cond_exec_stage against a flag/pipeline model
module tb_cond_exec_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall_m;
   logic        flush_e;
   logic        valid_e;
   logic [3:0]  cond_e;
   logic [1:0]  flagwrite_e;
   logic [3:0]  alu_flags_e;
   logic [31:0] alu_result_e;
   logic [31:0] write_data_e;
   logic [3:0]  wa_e;
   logic        regwrite_e;
   logic        memwrite_e;
   logic        pcsrc_e;
   logic        memtoreg_e;
   logic        cond_ex_e;
   logic [3:0]  flags_q;
   logic        valid_m;
   logic        regwrite_m;
   logic        memwrite_m;
   logic        pcsrc_m;
   logic        memtoreg_m;
   logic [31:0] alu_result_m;
   logic [31:0] write_data_m;
   logic [3:0]  wa_m;

   int errors = 0;
   int checks = 0;

   // reference model state
   logic [3:0]  m_flags;
   logic        m_valid;
   logic        m_rw;
   logic        m_mw;
   logic        m_pc;
   logic        m_mtr;
   logic [31:0] m_res;
   logic [31:0] m_wd;
   logic [3:0]  m_wa;

   cond_exec_stage #(.WIDTH(32), .RAW(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .stall_m      (stall_m),
      .flush_e      (flush_e),
      .valid_e      (valid_e),
      .cond_e       (cond_e),
      .flagwrite_e  (flagwrite_e),
      .alu_flags_e  (alu_flags_e),
      .alu_result_e (alu_result_e),
      .write_data_e (write_data_e),
      .wa_e         (wa_e),
      .regwrite_e   (regwrite_e),
      .memwrite_e   (memwrite_e),
      .pcsrc_e      (pcsrc_e),
      .memtoreg_e   (memtoreg_e),
      .cond_ex_e    (cond_ex_e),
      .flags_q      (flags_q),
      .valid_m      (valid_m),
      .regwrite_m   (regwrite_m),
      .memwrite_m   (memwrite_m),
      .pcsrc_m      (pcsrc_m),
      .memtoreg_m   (memtoreg_m),
      .alu_result_m (alu_result_m),
      .write_data_m (write_data_m),
      .wa_m         (wa_m)
   );

   always #5 clk = ~clk;

   // ARM condition truth table written from the N/Z/C/V meanings
   function automatic logic cond_holds(input logic [3:0] code, input logic [3:0] f);
      logic n, z, c, v;
      n = f[3]; z = f[2]; c = f[1]; v = f[0];
      case (code)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return c;
         4'd3:  return !c;
         4'd4:  return n;
         4'd5:  return !n;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return c && !z;
         4'd9:  return !c || z;
         4'd10: return n == v;
         4'd11: return n != v;
         4'd12: return !z && (n == v);
         4'd13: return z || (n != v);
         4'd14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Advance one clock and apply the same edge to the model
   task automatic tick();
      logic live, pass;
      live = valid_e && !flush_e;
      pass = live && cond_holds(cond_e, m_flags);
      @(posedge clk);
      if (reset) begin
         m_flags = 4'b0000; m_valid = 0; m_rw = 0; m_mw = 0; m_pc = 0; m_mtr = 0;
         m_res = 0; m_wd = 0; m_wa = 0;
      end else if (!stall_m) begin
         if (pass && flagwrite_e[1]) m_flags[3:2] = alu_flags_e[3:2];
         if (pass && flagwrite_e[0]) m_flags[1:0] = alu_flags_e[1:0];
         m_valid = live;
         m_rw  = regwrite_e && pass;
         m_mw  = memwrite_e && pass;
         m_pc  = pcsrc_e && pass;
         m_mtr = memtoreg_e && live;
         m_res = alu_result_e;
         m_wd  = write_data_e;
         m_wa  = wa_e;
      end
      #1;
   endtask

   task automatic idle_inputs();
      reset = 0; stall_m = 0; flush_e = 0; valid_e = 1; cond_e = 4'hE;
      flagwrite_e = 2'b00; alu_flags_e = 4'h0; alu_result_e = 0; write_data_e = 0;
      wa_e = 0; regwrite_e = 0; memwrite_e = 0; pcsrc_e = 0; memtoreg_e = 0;
   endtask

   task automatic load_flags(input logic [3:0] f);
      idle_inputs();
      flagwrite_e = 2'b11; alu_flags_e = f;
      tick();
      flagwrite_e = 2'b00;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1; regwrite_e = 1; memwrite_e = 1; alu_result_e = 32'hDEADBEEF;
      flagwrite_e = 2'b11; alu_flags_e = 4'hF;
      tick(); tick();
      checks++; if (flags_q !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", flags_q); end
      checks++; if (valid_m !== 1'b0) begin errors++; $display("FAIL reset_valid_m: got %b expected 0", valid_m); end
      checks++; if (regwrite_m !== 1'b0) begin errors++; $display("FAIL reset_regwrite_m: got %b expected 0", regwrite_m); end
      checks++; if (alu_result_m !== 32'h0) begin errors++; $display("FAIL reset_alu_result_m: got %h expected 0", alu_result_m); end
      reset = 0;
   endtask

   task automatic test_flag_forward();
      idle_inputs();
      cond_e = 4'b1110; flagwrite_e = 2'b11; alu_flags_e = 4'b0100;
      tick();
      checks++; if (flags_q !== 4'b0100) begin errors++; $display("FAIL fwd_flags: got %b expected 0100", flags_q); end
      cond_e = 4'b0000; flagwrite_e = 2'b00; regwrite_e = 1;
      #1;
      checks++; if (cond_ex_e !== 1'b1) begin errors++; $display("FAIL fwd_cond_ex_beq: got %b expected 1", cond_ex_e); end
      tick();
      checks++; if (regwrite_m !== 1'b1) begin errors++; $display("FAIL fwd_regwrite_m: got %b expected 1", regwrite_m); end
   endtask

   task automatic test_failed_cond();
      load_flags(4'b0100);
      cond_e = 4'b0001; memwrite_e = 1; flagwrite_e = 2'b11; alu_flags_e = 4'b1000;
      #1;
      checks++; if (cond_ex_e !== 1'b0) begin errors++; $display("FAIL ne_cond_ex: got %b expected 0", cond_ex_e); end
      tick();
      checks++; if (memwrite_m !== 1'b0) begin errors++; $display("FAIL ne_memwrite_m: got %b expected 0", memwrite_m); end
      checks++; if (valid_m !== 1'b1) begin errors++; $display("FAIL ne_valid_m: got %b expected 1", valid_m); end
      checks++; if (flags_q !== 4'b0100) begin errors++; $display("FAIL ne_flags_held: got %b expected 0100", flags_q); end
   endtask

   task automatic test_partial_write();
      load_flags(4'b1111);
      cond_e = 4'hE; flagwrite_e = 2'b10; alu_flags_e = 4'b0000;
      tick();
      checks++; if (flags_q !== 4'b0011) begin errors++; $display("FAIL partial_nz: got %b expected 0011", flags_q); end
      flagwrite_e = 2'b01; alu_flags_e = 4'b1100;
      tick();
      checks++; if (flags_q !== 4'b0000) begin errors++; $display("FAIL partial_cv: got %b expected 0000", flags_q); end
   endtask

   task automatic test_signed();
      load_flags(4'b1001);
      cond_e = 4'b1100; #1;
      checks++; if (cond_ex_e !== 1'b1) begin errors++; $display("FAIL gt_nv_eq: got %b expected 1", cond_ex_e); end
      cond_e = 4'b1011; #1;
      checks++; if (cond_ex_e !== 1'b0) begin errors++; $display("FAIL lt_nv_eq: got %b expected 0", cond_ex_e); end
      cond_e = 4'b1111; #1;
      checks++; if (cond_ex_e !== 1'b0) begin errors++; $display("FAIL never_1001: got %b expected 0", cond_ex_e); end
      load_flags(4'b1000);
      cond_e = 4'b1011; #1;
      checks++; if (cond_ex_e !== 1'b1) begin errors++; $display("FAIL lt_nv_ne: got %b expected 1", cond_ex_e); end
      cond_e = 4'b1010; #1;
      checks++; if (cond_ex_e !== 1'b0) begin errors++; $display("FAIL ge_nv_ne: got %b expected 0", cond_ex_e); end
      cond_e = 4'b1101; #1;
      checks++; if (cond_ex_e !== 1'b1) begin errors++; $display("FAIL le_nv_ne: got %b expected 1", cond_ex_e); end
      cond_e = 4'b1111; #1;
      checks++; if (cond_ex_e !== 1'b0) begin errors++; $display("FAIL never_1000: got %b expected 0", cond_ex_e); end
   endtask

   task automatic test_stall_flush();
      idle_inputs();
      flagwrite_e = 2'b11; alu_flags_e = 4'b0110;
      regwrite_e = 1; memwrite_e = 1; pcsrc_e = 1; memtoreg_e = 1;
      alu_result_e = 32'h1234_5678; write_data_e = 32'hCAFE_F00D; wa_e = 4'hA;
      tick();
      stall_m = 1; flush_e = 1; alu_flags_e = 4'b1111;
      alu_result_e = 32'h0BAD_0BAD; write_data_e = 32'h5555_AAAA; wa_e = 4'h3;
      tick();
      checks++; if (flags_q !== 4'b0110) begin errors++; $display("FAIL stall_flags: got %b expected 0110", flags_q); end
      checks++; if ({valid_m, regwrite_m, memwrite_m, pcsrc_m, memtoreg_m} !== 5'b11111) begin
         errors++; $display("FAIL stall_ctrls: got %b expected 11111", {valid_m, regwrite_m, memwrite_m, pcsrc_m, memtoreg_m}); end
      checks++; if ({alu_result_m, write_data_m, wa_m} !== {32'h1234_5678, 32'hCAFE_F00D, 4'hA}) begin
         errors++; $display("FAIL stall_data: got %h %h %h expected 12345678 cafef00d a", alu_result_m, write_data_m, wa_m); end
      stall_m = 0;
      tick();
      checks++; if ({valid_m, regwrite_m, memwrite_m, pcsrc_m, memtoreg_m} !== 5'b00000) begin
         errors++; $display("FAIL flush_ctrls: got %b expected 00000", {valid_m, regwrite_m, memwrite_m, pcsrc_m, memtoreg_m}); end
      checks++; if (flags_q !== 4'b0110) begin errors++; $display("FAIL flush_flags: got %b expected 0110", flags_q); end
      flush_e = 0; stall_m = 1; reset = 1;
      tick();
      checks++; if ({flags_q, valid_m, alu_result_m} !== 37'h0) begin
         errors++; $display("FAIL reset_in_stall: got %b %b %h expected all zero", flags_q, valid_m, alu_result_m); end
      idle_inputs();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         reset        = ($urandom_range(0, 39) == 0);
         stall_m      = ($urandom_range(0, 3) == 0);
         flush_e      = ($urandom_range(0, 5) == 0);
         valid_e      = ($urandom_range(0, 3) != 0);
         cond_e       = 4'($urandom);
         flagwrite_e  = 2'($urandom);
         alu_flags_e  = 4'($urandom);
         alu_result_e = $urandom;
         write_data_e = $urandom;
         wa_e         = 4'($urandom);
         regwrite_e   = 1'($urandom);
         memwrite_e   = 1'($urandom);
         pcsrc_e      = 1'($urandom);
         memtoreg_e   = 1'($urandom);
         #1;
         checks++;
         if (cond_ex_e !== (valid_e && !flush_e && cond_holds(cond_e, m_flags))) begin
            errors++; $display("FAIL rnd_cond_ex[%0d]: got %b cond %b flags %b", i, cond_ex_e, cond_e, m_flags);
         end
         tick();
         checks++;
         if ({flags_q, valid_m, regwrite_m, memwrite_m, pcsrc_m, memtoreg_m} !==
             {m_flags, m_valid, m_rw, m_mw, m_pc, m_mtr}) begin
            errors++; $display("FAIL rnd_state[%0d]: got %b_%b expected %b_%b", i, flags_q,
               {valid_m, regwrite_m, memwrite_m, pcsrc_m, memtoreg_m}, m_flags, {m_valid, m_rw, m_mw, m_pc, m_mtr});
         end
         checks++;
         if ({alu_result_m, write_data_m, wa_m} !== {m_res, m_wd, m_wa}) begin
            errors++; $display("FAIL rnd_data[%0d]: got %h %h %h expected %h %h %h", i,
               alu_result_m, write_data_m, wa_m, m_res, m_wd, m_wa);
         end
      end
      idle_inputs();
   endtask

   initial begin
      m_flags = 0; m_valid = 0; m_rw = 0; m_mw = 0; m_pc = 0; m_mtr = 0;
      m_res = 0; m_wd = 0; m_wa = 0;
      idle_inputs();
      test_reset();
      test_flag_forward();
      test_failed_cond();
      test_partial_write();
      test_signed();
      test_stall_flush();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cond_exec_stage.md
# cond_exec_stage

Execute-stage back end of the pipelined core. Sits directly downstream of the ALU: it holds the architectural NZCV flag register, evaluates each instruction's 4-bit condition field against it, gates the instruction's side-effect controls, and commits the ALU's flags. Its EX/MEM pipeline register carries result, store data, destination and gated controls into the memory stage.

## Interface
- WIDTH, 32, datapath width of ALU result and store data
- RAW, 4, register-address width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- stall_m  in  1  hold EX/MEM register and flags this cycle
- flush_e  in  1  kill the E-stage instruction (bubble into M)
- valid_e  in  1  E stage holds a real instruction
- cond_e  in  4  ARM condition field
- flagwrite_e  in  2  [1] writes N,Z; [0] writes C,V
- alu_flags_e  in  4  ALU flags {N,Z,C,V} (bit3=N … bit0=V)
- alu_result_e  in  WIDTH  ALU result
- write_data_e  in  WIDTH  store data
- wa_e  in  RAW  destination register
- regwrite_e, memwrite_e, pcsrc_e, memtoreg_e  in  1 each  ungated decode controls
- cond_ex_e  out  1  combinational: condition passed for the E-stage instruction
- flags_q  out  4  current NZCV register
- valid_m, regwrite_m, memwrite_m, pcsrc_m, memtoreg_m  out  1 each  registered controls
- alu_result_m, write_data_m  out  WIDTH  registered data
- wa_m  out  RAW  registered destination

## Operation
- Condition check against flags_q: 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C; 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V; 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 never 0.
- cond_ex_e = valid_e & ~flush_e & condmet.
- Flag commit, when ~stall_m & cond_ex_e:
  - flagwrite_e[1] loads bits 3:2 from alu_flags_e.
  - flagwrite_e[0] loads bits 1:0.
  - Unselected bits are held.
- EX/MEM register, when ~stall_m:
  - valid_m <= valid_e & ~flush_e.
  - regwrite_m, memwrite_m and pcsrc_m take their _e value ANDed with cond_ex_e.
  - memtoreg_m takes its _e value ANDed with valid_e & ~flush_e.
  - Data and wa_m load unconditionally (don't-care when the instruction is killed).
- stall_m high: every register holds; no flag write. Stall wins over a simultaneous flush; upstream keeps flush_e high until the stall clears.
- A failed condition leaves valid_m = 1 with all side-effect controls 0; flags are not written.

## Timing
- Reset (synchronous, dominates stall and flush): flags_q=0000, valid_m=0, every _m control 0, alu_result_m=0, write_data_m=0, wa_m=0.
- cond_ex_e: zero-latency, combinational from cond_e/valid_e/flush_e/flags_q.
- E→M latency: 1 cycle.
- Flags written at edge k are seen by the instruction in E at cycle k+1. Back-to-back CMP→BEQ needs no stall.
- Reset asserted mid-stall: state clears on that edge regardless of stall_m.

## Structure
- Package cond_pkg:
  - cond_t enum for the 16 codes.
  - Flag bit indices N_BIT=3, Z_BIT=2, C_BIT=1, V_BIT=0.
  - FW_NZ=1, FW_CV=0.
- Sub-module cond_check: combinational (cond_t, flags[3:0]) → met. Instantiated once.
- The flag register and the EX/MEM register live in cond_exec_stage.

## Test plan
- Reset: reset=1 for 2 cycles with valid_e=1, regwrite_e=1 → flags_q=0000, valid_m=0, regwrite_m=0.
- Flag update and forwarding:
  - Cycle 1: cond=1110, flagwrite=11, alu_flags=0100.
  - Cycle 2: cond=0000 (EQ), regwrite_e=1.
  - Required: flags_q=0100 after cycle 1; cond_ex_e=1 in cycle 2; regwrite_m=1 next edge.
- Failed condition:
  - Setup: flags_q=0100.
  - Stimulus: cond=0001 (NE), memwrite_e=1, flagwrite=11, alu_flags=1000.
  - Required: cond_ex_e=0, memwrite_m=0, valid_m=1, flags_q stays 0100.
- Partial write:
  - Setup: flags_q=1111.
  - Stimulus: AL, flagwrite=10, alu_flags=0000.
  - Required: flags_q=0011.
- Signed compares:
  - flags 1001 (N=V=1): GT=1 and LT=0.
  - flags 1000: LT=1, GE=0 and LE=1.
  - Code 1111 always gives 0.
- Stall/flush:
  - stall_m=1 with flush_e=1 → all _m outputs and flags_q held.
  - Next cycle, stall_m=0 with flush_e=1 → valid_m=0 and all gated controls 0.
